// File: rtl/sm83_irq_ctrl.sv
// ---------------------------------------------------------------------------
// sm83_irq_ctrl
//
// Interrupt controller for an SM83-style core. It holds the IE and IF
// registers, the master interrupt enable (IME) with its delayed-EI behaviour,
// the HALT state (including the HALT bug), and a six-state dispatch sequencer
// that tells the core when to push the PC and where to jump.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   irq_src[4:0]      one-cycle request pulses (0 VBlank, 1 STAT, 2 Timer,
//                     3 Serial, 4 Joypad)
//   ie_we, if_we      write strobes for IE / IF, data on wr_data[7:0]
//   ie_q, if_q        register readback (if_q[7:5] read as 1)
//   ei, di, reti      one-cycle pulses when the core executes that op
//   halt_req          HALT executed
//   instr_boundary    core is at an opcode fetch and can accept a dispatch
//   ime               master interrupt enable
//   halted            core fetch stalled while high
//   halt_bug          one-cycle pulse: do not increment PC on next fetch
//   busy              dispatch in progress (any non-IDLE state)
//   push_hi, push_lo  push PC high / low byte strobes
//   pc_load           load PC with {8'h00, vector}
//   vector            interrupt vector low byte, valid with pc_load
// ---------------------------------------------------------------------------
module sm83_irq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] irq_src,
  input  logic       ie_we,
  input  logic       if_we,
  input  logic [7:0] wr_data,
  output logic [7:0] ie_q,
  output logic [7:0] if_q,
  input  logic       ei,
  input  logic       di,
  input  logic       reti,
  input  logic       halt_req,
  input  logic       instr_boundary,
  output logic       ime,
  output logic       halted,
  output logic       halt_bug,
  output logic       busy,
  output logic       push_hi,
  output logic       push_lo,
  output logic       pc_load,
  output logic [7:0] vector
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_W1    = 3'd2,
    S_PUSHH = 3'd3,
    S_PUSHL = 3'd4,
    S_JUMP  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [4:0] if_bits;
  logic [4:0] if_next;
  logic [4:0] pending;
  logic       ei_pend;
  logic       ei_pend_next;
  logic       ime_next;
  logic       dispatch_start;

  // Priority choice, evaluated combinationally and latched at the PUSHL edge.
  logic [2:0] prio_idx;
  logic [2:0] irq_idx;
  logic       irq_valid;

  assign pending = ie_q[4:0] & if_bits;
  assign if_q    = {3'b111, if_bits};
  assign busy    = (state != S_IDLE);

  // A boundary that commits a delayed EI never dispatches; the interrupt is
  // taken at the following boundary instead.
  assign dispatch_start = (state == S_IDLE) && instr_boundary && ime &&
                          (pending != 5'd0) && !ei_pend && !halted;

  // Lowest set bit of pending has the highest priority.
  always_comb begin
    prio_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) prio_idx = 3'(i);
    end
  end

  // -------------------------------------------------------------------------
  // Dispatch FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) is kept to the combinational blocks.
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement leaves a signal unassigned (which would infer a latch).
    state_next = state;
    push_hi    = 1'b0;
    push_lo    = 1'b0;
    pc_load    = 1'b0;
    case (state)
      S_IDLE:  if (dispatch_start) state_next = S_W0;
      S_W0:    state_next = S_W1;
      S_W1:    state_next = S_PUSHH;
      S_PUSHH: begin
        push_hi    = 1'b1;
        state_next = S_PUSHL;
      end
      S_PUSHL: begin
        push_lo    = 1'b1;
        state_next = S_JUMP;
      end
      S_JUMP:  begin
        pc_load    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Priority is frozen at the PUSHL edge. If IE was rewritten during the push
  // so that nothing is pending any more, the jump goes to 0x00 and no IF bit
  // is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vector    <= 8'h00;
      irq_idx   <= 3'd0;
      irq_valid <= 1'b0;
    end else if (state == S_PUSHL) begin
      irq_idx   <= prio_idx;
      irq_valid <= (pending != 5'd0);
      vector    <= (pending != 5'd0) ? (8'h40 + {2'b00, prio_idx, 3'b000})
                                     : 8'h00;
    end
  end

  // -------------------------------------------------------------------------
  // IE / IF registers
  // -------------------------------------------------------------------------
  // IF update order: software write, then acknowledge in JUMP, then new
  // source pulses. A source pulse therefore always survives a same-cycle
  // write or acknowledge of its bit.
  always_comb begin
    if_next = if_we ? wr_data[4:0] : if_bits;
    if ((state == S_JUMP) && irq_valid) begin
      if_next = if_next & ~(5'b00001 << irq_idx);
    end
    if_next = if_next | irq_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only the architectural registers are reset; there is no
    // memory array here that would need to be left out of the reset.
    if (!rst_n) begin
      ie_q    <= 8'h00;
      if_bits <= 5'h00;
    end else begin
      if (ie_we) ie_q <= wr_data;
      if_bits <= if_next;
    end
  end

  // -------------------------------------------------------------------------
  // IME and delayed EI
  // -------------------------------------------------------------------------
  // Later assignments take precedence: DI beats everything, a dispatch start
  // beats RETI / EI commit. EI and RETI are ignored while a dispatch runs.
  always_comb begin
    ime_next     = ime;
    ei_pend_next = ei_pend;
    if (ei_pend && instr_boundary) begin
      ime_next     = 1'b1;
      ei_pend_next = 1'b0;
    end
    if (!busy) begin
      if (reti) ime_next     = 1'b1;
      if (ei)   ei_pend_next = 1'b1;
    end
    if (dispatch_start) ime_next = 1'b0;
    if (di) begin
      ime_next     = 1'b0;
      ei_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ime     <= 1'b0;
      ei_pend <= 1'b0;
    end else begin
      ime     <= ime_next;
      ei_pend <= ei_pend_next;
    end
  end

  // -------------------------------------------------------------------------
  // HALT
  // -------------------------------------------------------------------------
  // HALT with IME=0 and an interrupt already pending does not stop the core;
  // instead the next opcode byte is fetched twice (halt_bug). Any pending
  // interrupt wakes the core regardless of IME.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted   <= 1'b0;
      halt_bug <= 1'b0;
    end else begin
      halt_bug <= 1'b0;
      if (halted) begin
        if (pending != 5'd0) halted <= 1'b0;
      end else if (halt_req && !busy) begin
        if (ime || (pending == 5'd0)) halted   <= 1'b1;
        else                          halt_bug <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sm83_irq_ctrl.md
SM83_IRQ_CTRL -- requirements
Module: sm83_irq_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single core clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port irq_src  in  5  one-cycle request pulses; bit 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-004 SHALL have ports ie_we and if_we  in  1 each, plus wr_data  in  8; these are register write strobes and write data.
REQ-005 SHALL have ports ie_q  out  8 and if_q  out  8; these are register readback, with if_q[7:5] reading 1.
REQ-006 SHALL have ports ei, di and reti  in  1 each; each is a one-cycle pulse when the core executes that control op.
REQ-007 SHALL have ports halt_req  in  1 (HALT executed) and instr_boundary  in  1 (core at an opcode-fetch point, able to accept a dispatch).
REQ-008 SHALL have port ime  out  1, the master interrupt enable.
REQ-009 SHALL have port halted  out  1; while it is high the core stalls fetch.
REQ-010 SHALL have port halt_bug  out  1, a one-cycle pulse telling the core not to increment PC on the next fetch.
REQ-011 SHALL have port busy  out  1, high in every non-IDLE dispatch state; the core suppresses fetch while it is high.
REQ-012 SHALL have ports push_hi, push_lo and pc_load  out  1 each; these are sequencing strobes to the core datapath.
REQ-013 SHALL have port vector  out  8, the target address low byte, valid only with pc_load.

Function
REQ-014 SHALL compute pending = ie_q[4:0] & if_q[4:0] and hold it continuously.
REQ-015 SHALL OR irq_src into IF after any same-cycle if_we write, so a source always wins over a write or clear of the same bit.
REQ-016 SHALL clear IME and any EI pending flag on di, with IME low in the following cycle.
REQ-017 SHALL set IME on reti in the following cycle.
REQ-018 SHALL, on ei, set ei_pend and leave IME unchanged.
REQ-019 SHALL, at the first instr_boundary after ei_pend is set, take no dispatch, then set IME and clear ei_pend.
REQ-020 SHALL cause ei followed directly by di to leave IME at 0.
REQ-021 SHALL use a dispatch FSM with states IDLE, W0, W1, PUSHH, PUSHL and JUMP, advancing one state per cycle outside IDLE.
REQ-022 SHALL move IDLE->W0 when instr_boundary & ime & (pending != 0) & !busy, clearing IME in the same edge.
REQ-023 SHALL advance W0->W1->PUSHH->PUSHL->JUMP->IDLE in fixed order.
REQ-024 SHALL assert push_hi in PUSHH, push_lo in PUSHL, and pc_load in JUMP.
REQ-025 SHALL make dispatch latency 5 cycles from the qualifying boundary to pc_load.
REQ-026 SHALL resolve priority at the PUSHL edge, where the lowest set bit of pending wins, and latch that choice.
REQ-027 SHALL make vector 0x40 + 8*index.
REQ-028 SHALL, when pending is 0 at PUSHL (e.g. IE rewritten during the push), latch vector 0x00 and clear no IF bit.
REQ-029 SHALL clear the latched IF bit in JUMP, unless irq_src re-asserts that bit in the same cycle.
REQ-030 SHALL enter HALTED on halt_req when ime=1, or when ime=0 and pending=0; halted rises the next cycle.
REQ-031 SHALL, on halt_req with ime=0 and pending!=0, not halt and pulse halt_bug for one cycle.
REQ-032 SHALL exit HALTED one cycle after pending!=0, regardless of IME.
REQ-033 SHALL, on HALTED exit with ime=1, start dispatch at the next instr_boundary.
REQ-034 SHALL ignore ei, di and reti arriving while busy, except that di clears IME.

Reset
REQ-035 SHALL, while rst_n=0, set ie_q=0x00, if_q=0xE0, ime=0, ei_pend=0, halted=0, state=IDLE, vector=0x00, and all strobes and busy to 0.
REQ-036 SHALL, on reset during dispatch, abort immediately and emit no further strobes after release.

Verification
REQ-037 SHALL cover: IE=0x05, IME=1, irq_src=0x05 pulse, boundary -> push_hi at +3, push_lo at +4, pc_load with vector 0x40 at +5; IF then 0xE4.
REQ-038 SHALL cover: ei, then boundary with pending -> no dispatch, IME=1 after; next boundary dispatches.
REQ-039 SHALL cover: IE=0x01, IF=0x01, dispatch started, ie_we writes 0x00 during PUSHH -> vector 0x00, IF stays 0xE1.
REQ-040 SHALL cover: IME=0, IE=0x04, IF=0x04, halt_req -> halt_bug one cycle, halted stays 0.
REQ-041 SHALL cover: IME=0 halted, Timer pulse with IE=0x04 -> halted falls next cycle, no push strobes.
REQ-042 SHALL cover: rst_n low during PUSHL -> all strobes 0, if_q=0xE0, no pc_load after release.
